// File: rtl/ccx_ic_pkg.sv
// Shared types and memory-map constants for the core complex interconnect router.
package ccx_ic_pkg;

  localparam int CCX_AW      = 39;
  localparam int CCX_DW      = 64;
  localparam int CCX_RTYPE_W = 2;
  localparam int CCX_PRV_W   = 2;

  // Default regions: responder 0 owns [0, 256MB), responder 1 owns [256MB, 512MB).
  localparam logic [38:0] CCX_R0_BASE = 39'h00_0000_0000;
  localparam logic [38:0] CCX_R0_MASK = 39'h7F_F000_0000;
  localparam logic [38:0] CCX_R1_BASE = 39'h00_1000_0000;
  localparam logic [38:0] CCX_R1_MASK = 39'h7F_F000_0000;

  typedef enum logic [1:0] {
    TGT_NONE = 2'd0,
    TGT_T0   = 2'd1,
    TGT_T1   = 2'd2,
    TGT_TX   = 2'd3
  } rsp_tgt_e;

endpackage

// File: rtl/core_mem_bus.sv
// Core memory bus bundle: one request/grant channel with a fixed one-cycle response.
interface core_mem_bus
  import ccx_ic_pkg::*;
#(
  parameter int AW = CCX_AW,
  parameter int DW = CCX_DW
) ();

  logic                   req;
  logic [CCX_RTYPE_W-1:0] rtype;
  logic [AW-1:0]          addr;
  logic                   wen;
  logic [DW/8-1:0]        strb;
  logic [DW-1:0]          wdata;
  logic [CCX_PRV_W-1:0]   prv;
  logic                   gnt;
  logic                   err;
  logic [DW-1:0]          rdata;

  modport REQ (output req, rtype, addr, wen, strb, wdata, prv,
               input  gnt, err, rdata);
  modport RSP (input  req, rtype, addr, wen, strb, wdata, prv,
               output gnt, err, rdata);

endinterface

// File: rtl/ccx_ic_addr_decode.sv
// Base/mask region decode of a request address into per-responder hit flags.
module ccx_ic_addr_decode
  import ccx_ic_pkg::*;
#(
  parameter int            AW      = CCX_AW,
  parameter logic [AW-1:0] R0_BASE = AW'(CCX_R0_BASE),
  parameter logic [AW-1:0] R0_MASK = AW'(CCX_R0_MASK),
  parameter logic [AW-1:0] R1_BASE = AW'(CCX_R1_BASE),
  parameter logic [AW-1:0] R1_MASK = AW'(CCX_R1_MASK)
) (
  input  logic [AW-1:0] addr,
  output logic          hit0,
  output logic          hit1
);

  assign hit0 = (addr & R0_MASK) == R0_BASE;
  assign hit1 = (addr & R1_MASK) == R1_BASE;

endmodule

// File: rtl/ccx_ic_router.sv
// Steers one requestor to two responders by address; unmapped accesses are
// granted locally, answered with a bus error and logged in the err_* registers.
//
// Handshake: a request transfers on a cycle where req & gnt are both high; while
// req & !gnt the requestor holds every request field stable; the response
// (rdata/err) is valid exactly one cycle after the transfer and cannot be stalled.
module ccx_ic_router
  import ccx_ic_pkg::*;
#(
  parameter int            AW      = CCX_AW,
  parameter int            DW      = CCX_DW,
  parameter logic [AW-1:0] R0_BASE = AW'(CCX_R0_BASE),
  parameter logic [AW-1:0] R0_MASK = AW'(CCX_R0_MASK),
  parameter logic [AW-1:0] R1_BASE = AW'(CCX_R1_BASE),
  parameter logic [AW-1:0] R1_MASK = AW'(CCX_R1_MASK),
  parameter int            ECW     = 8
) (
  input  logic           g_clk,
  input  logic           g_resetn,
  core_mem_bus.RSP       req,
  core_mem_bus.REQ       rsp_0,
  core_mem_bus.REQ       rsp_1,
  input  logic           err_clear,
  output logic           err_valid,
  output logic [AW-1:0]  err_addr,
  output logic           err_wen,
  output logic [ECW-1:0] err_count,
  output logic [1:0]     dbg_rsp_tgt
);

  logic     hit0;
  logic     hit1;
  logic     sel0;
  logic     sel1;
  logic     selx;
  logic     gnt;
  rsp_tgt_e rsp_tgt;
  rsp_tgt_e tgt_nxt;

  ccx_ic_addr_decode #(
    .AW      (AW),
    .R0_BASE (R0_BASE),
    .R0_MASK (R0_MASK),
    .R1_BASE (R1_BASE),
    .R1_MASK (R1_MASK)
  ) u_decode (
    .addr (req.addr),
    .hit0 (hit0),
    .hit1 (hit1)
  );

  // Responder 0 wins when the two regions overlap.
  assign sel0 = req.req & hit0;
  assign sel1 = req.req & hit1 & ~hit0;
  assign selx = req.req & ~hit0 & ~hit1;

  assign rsp_0.req   = sel0;
  assign rsp_0.rtype = req.rtype;
  assign rsp_0.addr  = req.addr;
  assign rsp_0.wen   = req.wen;
  assign rsp_0.strb  = req.strb;
  assign rsp_0.wdata = req.wdata;
  assign rsp_0.prv   = req.prv;

  assign rsp_1.req   = sel1;
  assign rsp_1.rtype = req.rtype;
  assign rsp_1.addr  = req.addr;
  assign rsp_1.wen   = req.wen;
  assign rsp_1.strb  = req.strb;
  assign rsp_1.wdata = req.wdata;
  assign rsp_1.prv   = req.prv;

  assign gnt     = (sel0 & rsp_0.gnt) | (sel1 & rsp_1.gnt) | selx;
  assign req.gnt = gnt;

  always_comb begin
    tgt_nxt = TGT_NONE;
    if (gnt) begin
      if (sel0)      tgt_nxt = TGT_T0;
      else if (sel1) tgt_nxt = TGT_T1;
      else           tgt_nxt = TGT_TX;
    end
  end

  // Outputs are forced quiet while reset is held so a dropped response never pulses err.
  assign req.rdata = !g_resetn           ? '0          :
                     rsp_tgt == TGT_T0   ? rsp_0.rdata :
                     rsp_tgt == TGT_T1   ? rsp_1.rdata : '0;
  assign req.err   = g_resetn & (((rsp_tgt == TGT_T0) & rsp_0.err) |
                                 ((rsp_tgt == TGT_T1) & rsp_1.err) |
                                  (rsp_tgt == TGT_TX));

  assign dbg_rsp_tgt = rsp_tgt;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rsp_tgt   <= TGT_NONE;
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_wen   <= 1'b0;
      err_count <= '0;
    end else begin
      rsp_tgt <= tgt_nxt;
      // A capture in the same cycle as err_clear restarts the log with this access.
      if (selx) begin
        if (!err_valid || err_clear) begin
          err_addr <= req.addr;
          err_wen  <= req.wen;
        end
        err_valid <= 1'b1;
        if (err_clear)             err_count <= ECW'(1);
        else if (err_count != '1) err_count <= err_count + 1'b1;
      end else if (err_clear) begin
        err_valid <= 1'b0;
        err_count <= '0;
      end
    end
  end

  a_addr_stable: assert property (@(posedge g_clk) disable iff (!g_resetn)
    (req.req && !req.gnt) |=> $stable(req.addr));

endmodule

// File: doc/ccx_ic_router.md
Name: ccx_ic_router

Overview:
- Core complex interconnect router: the inverse of the two-into-one interconnect arbiter.
- Takes one core_mem_bus requestor and steers each request to one of two responders by address decode.
- Steers each one-cycle-later response back to the requestor.
- Requests to unmapped addresses are granted locally and answered with a bus error; the first faulting address is captured for software.

Parameters:
AW, 39, address width
DW, 64, data width
R0_BASE, 39'h00_0000_0000, responder 0 region base (aligned to R0_MASK)
R0_MASK, 39'h7F_F000_0000, responder 0 compare mask; hit0 = (addr & R0_MASK) == R0_BASE
R1_BASE, 39'h00_1000_0000, responder 1 region base
R1_MASK, 39'h7F_F000_0000, responder 1 compare mask
ECW, 8, width of unmapped-access counter

Ports:
g_clk  input  1  clock
g_resetn  input  1  synchronous active-low reset
req  core_mem_bus.RSP  bundle  upstream requestor (req, rtype, addr[AW], wen, strb[DW/8], wdata[DW], prv in; gnt, err, rdata[DW] out)
rsp_0  core_mem_bus.REQ  bundle  responder 0
rsp_1  core_mem_bus.REQ  bundle  responder 1
err_clear  input  1  clears capture state
err_valid  output  1  sticky: an unmapped access has been captured
err_addr  output  AW  address of first captured unmapped access
err_wen  output  1  wen of captured access
err_count  output  ECW  saturating count of unmapped accesses

Behaviour:
- Reset (g_resetn=0 at posedge g_clk) clears all state:
  - rsp_tgt=NONE, err_valid=0, err_addr=0, err_wen=0, err_count=0.
  - Consequently req.err=0 and req.rdata=0 in the first cycle after reset.
- Decode, combinational on req.addr:
  - sel0 = req.req & hit0.
  - sel1 = req.req & hit1 & !hit0 (responder 0 wins overlap).
  - selx = req.req & !hit0 & !hit1.
- Request path:
  - rsp_n.req = sel_n.
  - rtype/addr/wen/strb/wdata/prv are broadcast unmodified to both responders.
  - A non-selected responder never sees req high.
- Grant: req.gnt = (sel0 & rsp_0.gnt) | (sel1 & rsp_1.gnt) | selx.
  - Unmapped requests are granted in the same cycle; zero wait states.
- Protocol rule: the requestor holds all request fields stable while req & !gnt.
  - Target selection therefore never changes mid-request.
  - A simulation-only assertion flags addr changing while req & !gnt.
- Response tracking: 2-bit rsp_tgt register in {NONE, T0, T1, TX}.
  - On req.req & req.gnt, rsp_tgt <= T0/T1/TX per the selection; otherwise rsp_tgt <= NONE.
- Response, the cycle after the grant:
  - req.rdata = rsp_0.rdata (T0), rsp_1.rdata (T1), 0 (TX/NONE).
  - req.err = (T0 & rsp_0.err) | (T1 & rsp_1.err) | TX.
  - Responder err is ignored when it is not the tracked target.
- Back-to-back: a new grant may coincide with the previous response.
  - Pipeline depth is exactly 1; there is no backpressure on responses.
- Error capture, on selx & req.gnt:
  - If !err_valid (after clear), load err_addr/err_wen and set err_valid.
  - err_count increments, saturating at 2^ECW-1.
- err_clear:
  - Sets err_valid=0 and err_count=0 next cycle.
  - If an unmapped grant occurs in the same cycle, the capture wins: err_valid=1, err_addr=new address, err_count=1.
- Reset mid-transaction: any outstanding response is dropped, with no err pulse.
  - The requestor must re-issue.

Decomposition:
- ccx_ic_pkg:
  - rsp_tgt enum (NONE=0, T0=1, T1=2, TX=3).
  - Default region BASE/MASK constants shared with the memory map.
- Sub-module ccx_ic_addr_decode: pure combinational (addr, BASE/MASK parameters) -> {hit0, hit1}, one instance per router.
  - Reused by future N-way routers.

Test Plan:
- Read addr 0x0000_0040; rsp_0.gnt held low 2 cycles then high -> req.gnt high only in cycle 3, rsp_1.req never high, rdata=rsp_0.rdata (0xDEAD_BEEF) next cycle.
- Write addr 0x1000_0008, rsp_1.gnt=1, rsp_1.err=1 next cycle -> req.err=1; concurrent rsp_0.err=1 ignored.
- Back-to-back T0 then T1 then T0 granted each cycle, responders return distinct rdata -> each response routed to the correct cycle, no mixing.
- Unmapped read 0x20_0000_0000 -> gnt same cycle, err=1 and rdata=0 next cycle, neither responder req; err_valid=1, err_addr=0x20_0000_0000, err_count=1; second unmapped at 0x30_0000_0000 -> err_addr unchanged, count=2.
- err_clear coincident with unmapped write to 0x40_0000_0000 -> err_valid=1, err_addr=0x40_0000_0000, err_wen=1, err_count=1; 260 unmapped accesses -> count saturates at 255.
- Reset asserted the cycle after a T0 grant -> req.err=0, rsp_tgt=NONE, all err_* outputs 0.
